// File: rtl/apu_pkg.sv
// Shared APU definitions: duty waveform table, envelope direction and default widths.
package apu_pkg;

  localparam int DEF_FREQ_W = 11;
  localparam int DEF_LEN_W  = 6;
  localparam int DEF_VOL_W  = 4;
  localparam int DEF_ENV_W  = 3;

  typedef enum logic {
    ENV_DOWN = 1'b0,
    ENV_UP   = 1'b1
  } env_dir_e;

  // Bit n of each entry is the waveform level at sequencer step n.
  localparam logic [3:0][7:0] DUTY_TABLE = {
    8'b01111110,
    8'b10000111,
    8'b10000001,
    8'b00000001
  };

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pat;
    pat = DUTY_TABLE[duty];
    return pat[step];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// Volume envelope: period timer, up/down volume stepping and sticky saturation.
module apu_envelope
  import apu_pkg::*;
#(
  parameter int VOL_W = DEF_VOL_W,
  parameter int ENV_W = DEF_ENV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             tick,
  input  logic [VOL_W-1:0] init,
  input  env_dir_e         dir,
  input  logic [ENV_W-1:0] period,
  output logic [VOL_W-1:0] vol
);

  localparam logic [VOL_W-1:0] VOL_MAX = '1;

  logic [VOL_W-1:0] vol_d, vol_q;
  logic [ENV_W-1:0] env_tmr_d, env_tmr_q;
  logic             sat_d, sat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vol_q     <= '0;
      env_tmr_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      vol_q     <= vol_d;
      env_tmr_q <= env_tmr_d;
      sat_q     <= sat_d;
    end
  end

  // Once a step is refused at either rail, volume is frozen until the next load.
  always_comb begin
    vol_d     = vol_q;
    env_tmr_d = env_tmr_q;
    sat_d     = sat_q;
    if (load) begin
      vol_d     = init;
      env_tmr_d = period;
      sat_d     = 1'b0;
    end else if (tick && (period != '0)) begin
      if (env_tmr_q > ENV_W'(1)) begin
        env_tmr_d = env_tmr_q - ENV_W'(1);
      end else begin
        env_tmr_d = period;
        if (!sat_q) begin
          if (dir == ENV_UP) begin
            if (vol_q == VOL_MAX) sat_d = 1'b1;
            else                  vol_d = vol_q + VOL_W'(1);
          end else begin
            if (vol_q == '0) sat_d = 1'b1;
            else             vol_d = vol_q - VOL_W'(1);
          end
        end
      end
    end
  end

  assign vol = vol_q;

endmodule

// File: rtl/pulse_channel.sv
// Square-wave APU channel: frequency timer, duty sequencer, length counter,
// volume envelope and an optional channel-1 style frequency sweep.
module pulse_channel
  import apu_pkg::*;
#(
  parameter int FREQ_W   = DEF_FREQ_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int VOL_W    = DEF_VOL_W,
  parameter int ENV_W    = DEF_ENV_W,
  parameter int SWEEP_EN = 0
) (
  input  logic              amuk_4mhz,
  input  logic              napu_reset,
  input  logic              freq_ce,
  input  logic              len_tick,
  input  logic              env_tick,
  input  logic              sweep_tick,
  input  logic              trig,
  input  logic              len_load,
  input  logic [LEN_W-1:0]  len_data,
  input  logic              len_en,
  input  logic [1:0]        duty,
  input  logic [FREQ_W-1:0] freq,
  input  logic [VOL_W-1:0]  env_init,
  input  logic              env_up,
  input  logic [ENV_W-1:0]  env_period,
  input  logic [2:0]        sw_period,
  input  logic              sw_down,
  input  logic [2:0]        sw_shift,
  output logic [VOL_W-1:0]  out,
  output logic              active,
  output logic              dac_en,
  output logic [FREQ_W-1:0] sw_freq
);

  localparam logic [FREQ_W-1:0] FREQ_MAX   = '1;
  localparam logic [FREQ_W:0]   FREQ_LIMIT = {1'b0, FREQ_MAX};
  localparam logic [LEN_W:0]    LEN_FULL   = {1'b1, {LEN_W{1'b0}}};
  localparam logic [LEN_W:0]    LEN_ONE    = {{LEN_W{1'b0}}, 1'b1};

  logic [FREQ_W-1:0] tmr_d, tmr_q;
  logic [2:0]        step_d, step_q;
  logic [LEN_W:0]    len_cnt_d, len_cnt_q;
  logic              active_d, active_q;
  logic [VOL_W-1:0]  out_d, out_q;

  logic              dac_en_w;
  logic              trig_go;
  logic [FREQ_W-1:0] sw_freq_w;
  logic              sw_kill;
  logic [VOL_W-1:0]  vol;

  assign dac_en_w = (env_init != '0) || env_up;
  assign trig_go  = trig && dac_en_w;

  function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] base,
                                                 input logic [2:0]        shift,
                                                 input logic              down);
    logic [FREQ_W:0] b;
    logic [FREQ_W:0] delta;
    b     = {1'b0, base};
    delta = b >> shift;
    return down ? (b - delta) : (b + delta);
  endfunction

  apu_envelope #(
    .VOL_W (VOL_W),
    .ENV_W (ENV_W)
  ) u_env (
    .clk    (amuk_4mhz),
    .rst_n  (napu_reset),
    .load   (trig_go),
    .tick   (env_tick && !trig_go),
    .init   (env_init),
    .dir    (env_dir_e'(env_up)),
    .period (env_period),
    .vol    (vol)
  );

  generate
    if (SWEEP_EN != 0) begin : g_sweep
      logic [FREQ_W-1:0] shadow_d, shadow_q;
      logic [3:0]        sw_tmr_d, sw_tmr_q;
      logic              sw_on_d, sw_on_q;
      logic [3:0]        sw_reload;
      logic [FREQ_W:0]   calc_a, calc_b;
      logic              kill;

      assign sw_reload = (sw_period != 3'd0) ? {1'b0, sw_period} : 4'd8;

      always_ff @(posedge amuk_4mhz) begin
        if (!napu_reset) begin
          shadow_q <= '0;
          sw_tmr_q <= '0;
          sw_on_q  <= 1'b0;
        end else begin
          shadow_q <= shadow_d;
          sw_tmr_q <= sw_tmr_d;
          sw_on_q  <= sw_on_d;
        end
      end

      // A successful sweep write is immediately re-checked against the new shadow.
      always_comb begin
        shadow_d = shadow_q;
        sw_tmr_d = sw_tmr_q;
        sw_on_d  = sw_on_q;
        calc_a   = '0;
        calc_b   = '0;
        kill     = 1'b0;
        if (trig_go) begin
          shadow_d = freq;
          sw_tmr_d = sw_reload;
          sw_on_d  = (sw_period != 3'd0) || (sw_shift != 3'd0);
          calc_a   = sweep_calc(freq, sw_shift, sw_down);
          if ((sw_shift != 3'd0) && (calc_a > FREQ_LIMIT)) kill = 1'b1;
        end else if (sweep_tick) begin
          if (sw_tmr_q > 4'd1) begin
            sw_tmr_d = sw_tmr_q - 4'd1;
          end else begin
            sw_tmr_d = sw_reload;
            if (sw_on_q && (sw_period != 3'd0)) begin
              calc_a = sweep_calc(shadow_q, sw_shift, sw_down);
              if (calc_a > FREQ_LIMIT) begin
                kill = 1'b1;
              end else if (sw_shift != 3'd0) begin
                shadow_d = calc_a[FREQ_W-1:0];
                calc_b   = sweep_calc(calc_a[FREQ_W-1:0], sw_shift, sw_down);
                if (calc_b > FREQ_LIMIT) kill = 1'b1;
              end
            end
          end
        end
      end

      assign sw_freq_w = shadow_q;
      assign sw_kill   = kill;
    end else begin : g_no_sweep
      logic unused_sweep;
      assign unused_sweep = ^{sweep_tick, sw_period, sw_down, sw_shift};
      assign sw_freq_w    = freq;
      assign sw_kill      = 1'b0;
    end
  endgenerate

  always_ff @(posedge amuk_4mhz) begin
    if (!napu_reset) begin
      tmr_q     <= '0;
      step_q    <= '0;
      len_cnt_q <= '0;
      active_q  <= 1'b0;
      out_q     <= '0;
    end else begin
      tmr_q     <= tmr_d;
      step_q    <= step_d;
      len_cnt_q <= len_cnt_d;
      active_q  <= active_d;
      out_q     <= out_d;
    end
  end

  // On trigger the timer loads freq directly: the sweep shadow takes the same value that edge.
  always_comb begin
    tmr_d     = tmr_q;
    step_d    = step_q;
    len_cnt_d = len_cnt_q;
    active_d  = active_q;
    if (trig_go) begin
      tmr_d    = freq;
      step_d   = 3'd0;
      active_d = 1'b1;
      if (len_cnt_q == '0) len_cnt_d = LEN_FULL;
    end else if (freq_ce) begin
      if (tmr_q == FREQ_MAX) begin
        tmr_d  = sw_freq_w;
        step_d = step_q + 3'd1;
      end else begin
        tmr_d = tmr_q + FREQ_W'(1);
      end
    end
    if (len_load) begin
      len_cnt_d = LEN_FULL - {1'b0, len_data};
    end else if (!trig_go && len_tick && len_en && (len_cnt_q != '0)) begin
      len_cnt_d = len_cnt_q - LEN_ONE;
      if (len_cnt_q == LEN_ONE) active_d = 1'b0;
    end
    if (sw_kill)   active_d = 1'b0;
    if (!dac_en_w) active_d = 1'b0;
  end

  always_comb begin
    out_d = '0;
    if (active_q && duty_bit(duty, step_q)) out_d = vol;
  end

  assign out     = out_q;
  assign active  = active_q;
  assign dac_en  = dac_en_w;
  assign sw_freq = sw_freq_w;

endmodule

// File: tb/tb_pulse_channel.sv
// Self-checking bench for pulse_channel: directed tables and sequences plus
// random stimulus against a behavioural model, on a plain and a sweep instance.
module tb_pulse_channel;

  typedef struct {
    bit       rst_n;
    bit       freq_ce;
    bit       len_tick;
    bit       env_tick;
    bit       sweep_tick;
    bit       trig;
    bit       len_load;
    bit [5:0] len_data;
    bit       len_en;
    bit [1:0] duty;
    bit [10:0] freq;
    bit [3:0] env_init;
    bit       env_up;
    bit [2:0] env_period;
    bit [2:0] sw_period;
    bit       sw_down;
    bit [2:0] sw_shift;
  } stim_t;

  typedef struct {
    int active;
    int tmr;
    int step;
    int len_cnt;
    int vol;
    int env_tmr;
    int sat;
    int shadow;
    int sw_tmr;
    int sw_on;
    int out;
  } model_t;

  typedef struct {
    bit rst_n;
    bit trig;
    bit ce;
    int exp_active;
    int exp_out;
  } vec_t;

  logic        amuk_4mhz = 1'b0;
  logic        napu_reset, freq_ce, len_tick, env_tick, sweep_tick, trig, len_load, len_en;
  logic        env_up, sw_down;
  logic [5:0]  len_data;
  logic [1:0]  duty;
  logic [10:0] freq;
  logic [3:0]  env_init;
  logic [2:0]  env_period, sw_period, sw_shift;
  logic [3:0]  out_a, out_s;
  logic        active_a, active_s, dac_en_a, dac_en_s;
  logic [10:0] sw_freq_a, sw_freq_s;

  int     checks   = 0;
  int     failures = 0;
  bit     model_on = 1'b0;
  stim_t  cur;
  model_t m_a, m_s;
  bit [7:0] tb_pat [4];

  always #5 amuk_4mhz = ~amuk_4mhz;

  pulse_channel #(.SWEEP_EN(0)) dut (
    .amuk_4mhz (amuk_4mhz), .napu_reset (napu_reset), .freq_ce (freq_ce),
    .len_tick (len_tick), .env_tick (env_tick), .sweep_tick (sweep_tick),
    .trig (trig), .len_load (len_load), .len_data (len_data), .len_en (len_en),
    .duty (duty), .freq (freq), .env_init (env_init), .env_up (env_up),
    .env_period (env_period), .sw_period (sw_period), .sw_down (sw_down),
    .sw_shift (sw_shift), .out (out_a), .active (active_a), .dac_en (dac_en_a),
    .sw_freq (sw_freq_a)
  );

  pulse_channel #(.SWEEP_EN(1)) dut_sw (
    .amuk_4mhz (amuk_4mhz), .napu_reset (napu_reset), .freq_ce (freq_ce),
    .len_tick (len_tick), .env_tick (env_tick), .sweep_tick (sweep_tick),
    .trig (trig), .len_load (len_load), .len_data (len_data), .len_en (len_en),
    .duty (duty), .freq (freq), .env_init (env_init), .env_up (env_up),
    .env_period (env_period), .sw_period (sw_period), .sw_down (sw_down),
    .sw_shift (sw_shift), .out (out_s), .active (active_s), .dac_en (dac_en_s),
    .sw_freq (sw_freq_s)
  );

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{default: 0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic int sweep_new(int base, int shift, bit down);
    int d;
    d = base >> shift;
    return down ? base - d : base + d;
  endfunction

  // Reference behaviour of one channel for one clock edge, written from the channel rules.
  function automatic model_t model_next(model_t m, bit sweep, stim_t s);
    model_t n;
    bit [7:0] p;
    bit dac, go;
    int feff, t, nw;
    n = m;
    if (!s.rst_n) begin
      n = '{default: 0};
      return n;
    end
    dac  = (s.env_init != 0) || s.env_up;
    go   = s.trig && dac;
    feff = sweep ? m.shadow : int'(s.freq);
    p    = tb_pat[s.duty];
    n.out = (m.active != 0 && p[m.step] == 1'b1) ? m.vol : 0;
    if (go) begin
      n.active  = 1;
      n.tmr     = s.freq;
      n.step    = 0;
      n.vol     = s.env_init;
      n.env_tmr = s.env_period;
      n.sat     = 0;
      if (m.len_cnt == 0) n.len_cnt = 64;
      if (sweep) begin
        n.shadow = s.freq;
        n.sw_tmr = (s.sw_period != 0) ? int'(s.sw_period) : 8;
        n.sw_on  = (s.sw_period != 0 || s.sw_shift != 0) ? 1 : 0;
        if (s.sw_shift != 0 && sweep_new(s.freq, s.sw_shift, s.sw_down) > 2047) n.active = 0;
      end
    end else begin
      if (s.freq_ce) begin
        if (m.tmr == 2047) begin
          n.tmr  = feff;
          n.step = (m.step + 1) % 8;
        end else begin
          n.tmr = m.tmr + 1;
        end
      end
      if (s.len_tick && s.len_en && m.len_cnt != 0 && !s.len_load) begin
        n.len_cnt = m.len_cnt - 1;
        if (n.len_cnt == 0) n.active = 0;
      end
      if (s.env_tick && s.env_period != 0) begin
        t = m.env_tmr - 1;
        if (t <= 0) begin
          n.env_tmr = s.env_period;
          if (m.sat == 0) begin
            if (s.env_up) begin
              if (m.vol == 15) n.sat = 1; else n.vol = m.vol + 1;
            end else begin
              if (m.vol == 0) n.sat = 1; else n.vol = m.vol - 1;
            end
          end
        end else begin
          n.env_tmr = t;
        end
      end
      if (sweep && s.sweep_tick) begin
        t = m.sw_tmr - 1;
        if (t <= 0) begin
          n.sw_tmr = (s.sw_period != 0) ? int'(s.sw_period) : 8;
          if (m.sw_on != 0 && s.sw_period != 0) begin
            nw = sweep_new(m.shadow, s.sw_shift, s.sw_down);
            if (nw > 2047) n.active = 0;
            else if (s.sw_shift != 0) begin
              n.shadow = nw;
              if (sweep_new(nw, s.sw_shift, s.sw_down) > 2047) n.active = 0;
            end
          end
        end else begin
          n.sw_tmr = t;
        end
      end
    end
    if (s.len_load) n.len_cnt = 64 - int'(s.len_data);
    if (!dac) n.active = 0;
    return n;
  endfunction

  task automatic applyStimulus(input stim_t s);
    cur        = s;
    napu_reset = s.rst_n;
    freq_ce    = s.freq_ce;
    len_tick   = s.len_tick;
    env_tick   = s.env_tick;
    sweep_tick = s.sweep_tick;
    trig       = s.trig;
    len_load   = s.len_load;
    len_data   = s.len_data;
    len_en     = s.len_en;
    duty       = s.duty;
    freq       = s.freq;
    env_init   = s.env_init;
    env_up     = s.env_up;
    env_period = s.env_period;
    sw_period  = s.sw_period;
    sw_down    = s.sw_down;
    sw_shift   = s.sw_shift;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkModel();
    int dac;
    dac = (cur.env_init != 0 || cur.env_up) ? 1 : 0;
    checkOutput("rand_out_a",     int'(out_a),     m_a.out);
    checkOutput("rand_active_a",  int'(active_a),  m_a.active);
    checkOutput("rand_dac_en_a",  int'(dac_en_a),  dac);
    checkOutput("rand_sw_freq_a", int'(sw_freq_a), int'(cur.freq));
    checkOutput("rand_out_s",     int'(out_s),     m_s.out);
    checkOutput("rand_active_s",  int'(active_s),  m_s.active);
    checkOutput("rand_dac_en_s",  int'(dac_en_s),  dac);
    checkOutput("rand_sw_freq_s", int'(sw_freq_s), m_s.shadow);
  endtask

  task automatic stepCycle();
    @(posedge amuk_4mhz);
    m_a = model_next(m_a, 1'b0, cur);
    m_s = model_next(m_s, 1'b1, cur);
    @(negedge amuk_4mhz);
    if (model_on) checkModel();
  endtask

  initial begin
    stim_t s;
    vec_t  vec [19];
    int    exp_out [19];

    tb_pat  = '{8'b00000001, 8'b10000001, 8'b10000111, 8'b01111110};
    m_a     = '{default: 0};
    m_s     = '{default: 0};
    exp_out = '{0, 0, 9, 9, 9, 9, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9};
    for (int i = 0; i < 19; i++) begin
      vec[i].rst_n      = (i != 0);
      vec[i].trig       = (i == 1);
      vec[i].ce         = (i != 0);
      vec[i].exp_active = (i != 0) ? 1 : 0;
      vec[i].exp_out    = exp_out[i];
    end

    // Duty 2 at freq 2046: one step per two timer clocks, high on steps 0,1,2,7.
    for (int i = 0; i < 19; i++) begin
      s = idle_stim();
      s.rst_n    = vec[i].rst_n;
      s.trig     = vec[i].trig;
      s.freq_ce  = vec[i].ce;
      s.freq     = 11'd2046;
      s.duty     = 2'd2;
      s.env_init = 4'd9;
      applyStimulus(s);
      stepCycle();
      checkOutput($sformatf("duty_row%0d_active", i), int'(active_a), vec[i].exp_active);
      checkOutput($sformatf("duty_row%0d_out", i), int'(out_a), vec[i].exp_out);
      checkOutput($sformatf("duty_row%0d_out_sw", i), int'(out_s), vec[i].exp_out);
      if (i == 0) checkOutput("reset_sw_freq", int'(sw_freq_s), 0);
    end

    // Length: load 62 leaves two ticks of life.
    s = idle_stim();
    s.env_init = 4'd9; s.freq = 11'd2046; s.len_en = 1'b1;
    s.len_load = 1'b1; s.len_data = 6'd62;
    applyStimulus(s); stepCycle();
    checkOutput("len_load_cnt", int'(dut.len_cnt_q), 2);
    s.len_load = 1'b0; s.trig = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("len_trig_active", int'(active_a), 1);
    s.trig = 1'b0; s.len_tick = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("len_tick1_active", int'(active_a), 1);
    applyStimulus(s); stepCycle();
    checkOutput("len_tick2_active", int'(active_a), 0);
    applyStimulus(s); stepCycle();
    checkOutput("len_tick3_active", int'(active_a), 0);
    checkOutput("len_tick3_cnt", int'(dut.len_cnt_q), 0);
    checkOutput("len_tick3_out", int'(out_a), 0);

    // Envelope up from 14 saturates at 15.
    s = idle_stim();
    s.env_init = 4'd14; s.env_up = 1'b1; s.env_period = 3'd1; s.trig = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("env_up_trig_active", int'(active_a), 1);
    s.trig = 1'b0; s.env_tick = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("env_up_tick1_out", int'(out_a), 14);
    applyStimulus(s); stepCycle();
    checkOutput("env_up_tick2_out", int'(out_a), 15);
    applyStimulus(s); stepCycle();
    checkOutput("env_up_tick3_out", int'(out_a), 15);
    s.env_tick = 1'b0;
    applyStimulus(s); stepCycle();
    checkOutput("env_up_hold_out", int'(out_a), 15);

    // Envelope down from 1 hits 0 and stays there, even if the direction flips.
    s.env_init = 4'd1; s.env_up = 1'b0; s.trig = 1'b1;
    applyStimulus(s); stepCycle();
    s.trig = 1'b0; s.env_tick = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("env_dn_tick1_out", int'(out_a), 1);
    s.env_tick = 1'b0;
    applyStimulus(s); stepCycle();
    checkOutput("env_dn_zero_out", int'(out_a), 0);
    s.env_tick = 1'b1;
    applyStimulus(s); stepCycle();
    applyStimulus(s); stepCycle();
    s.env_up = 1'b1;
    applyStimulus(s); stepCycle();
    s.env_tick = 1'b0;
    applyStimulus(s); stepCycle();
    checkOutput("env_sat_hold_out", int'(out_a), 0);
    checkOutput("env_sat_active", int'(active_a), 1);

    // DAC off: trigger ignored; clearing env_init stops a running channel.
    s = idle_stim();
    applyStimulus(s); stepCycle();
    checkOutput("dac_off_dac_en", int'(dac_en_a), 0);
    checkOutput("dac_off_active", int'(active_a), 0);
    s.trig = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("dac_off_trig_active", int'(active_a), 0);
    s.env_init = 4'd5;
    applyStimulus(s); stepCycle();
    checkOutput("dac_on_dac_en", int'(dac_en_a), 1);
    checkOutput("dac_on_trig_active", int'(active_a), 1);
    s.trig = 1'b0; s.env_init = 4'd0;
    applyStimulus(s); stepCycle();
    checkOutput("dac_clear_active", int'(active_a), 0);

    // Sweep: 1024 up by >>1 gives 1536, whose next step overflows.
    s = idle_stim(); s.rst_n = 1'b0;
    applyStimulus(s); stepCycle();
    s = idle_stim();
    s.freq = 11'd1024; s.sw_shift = 3'd1; s.sw_period = 3'd1; s.env_init = 4'd9; s.trig = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("sweep_trig_active", int'(active_s), 1);
    checkOutput("sweep_trig_freq", int'(sw_freq_s), 1024);
    checkOutput("nosweep_freq", int'(sw_freq_a), 1024);
    s.trig = 1'b0; s.sweep_tick = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("sweep_tick_freq", int'(sw_freq_s), 1536);
    checkOutput("sweep_tick_active", int'(active_s), 0);
    checkOutput("nosweep_tick_active", int'(active_a), 1);
    s.sweep_tick = 1'b0; s.freq = 11'd1400; s.trig = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("sweep_trig_ovf_active", int'(active_s), 0);
    checkOutput("sweep_trig_ovf_freq", int'(sw_freq_s), 1400);
    s.sw_down = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("sweep_down_trig_active", int'(active_s), 1);
    s.trig = 1'b0; s.sweep_tick = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("sweep_down_freq", int'(sw_freq_s), 700);
    checkOutput("sweep_down_active", int'(active_s), 1);

    // Trigger with coincident ticks: ticks are dropped.
    s = idle_stim(); s.rst_n = 1'b0;
    applyStimulus(s); stepCycle();
    s = idle_stim();
    s.trig = 1'b1; s.len_tick = 1'b1; s.len_en = 1'b1; s.env_tick = 1'b1;
    s.env_init = 4'd7; s.env_period = 3'd1;
    applyStimulus(s); stepCycle();
    checkOutput("coinc_len_cnt", int'(dut.len_cnt_q), 64);
    checkOutput("coinc_vol", int'(dut.u_env.vol_q), 7);
    s.trig = 1'b0; s.len_tick = 1'b0; s.env_tick = 1'b0;
    applyStimulus(s); stepCycle();
    checkOutput("coinc_out", int'(out_a), 7);

    // Reset mid-run with strobes present.
    s.rst_n = 1'b0; s.trig = 1'b1; s.len_tick = 1'b1; s.env_tick = 1'b1; s.sweep_tick = 1'b1;
    applyStimulus(s); stepCycle();
    checkOutput("rst_out_a", int'(out_a), 0);
    checkOutput("rst_active_a", int'(active_a), 0);
    checkOutput("rst_out_s", int'(out_s), 0);
    checkOutput("rst_active_s", int'(active_s), 0);
    checkOutput("rst_sw_freq_s", int'(sw_freq_s), 0);

    // Random run against the reference model.
    s = idle_stim(); s.rst_n = 1'b0;
    applyStimulus(s); stepCycle();
    model_on = 1'b1;
    s = idle_stim();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 79) == 0 || c == 0) begin
        s.duty       = 2'($urandom_range(0, 3));
        s.freq       = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 2047))
                                                   : 11'($urandom_range(1990, 2047));
        s.env_init   = 4'($urandom_range(0, 15));
        s.env_up     = ($urandom_range(0, 2) == 0);
        s.env_period = 3'($urandom_range(0, 7));
        s.sw_period  = 3'($urandom_range(0, 7));
        s.sw_shift   = 3'($urandom_range(0, 7));
        s.sw_down    = ($urandom_range(0, 1) == 0);
        s.len_en     = ($urandom_range(0, 3) != 0);
      end
      s.rst_n      = ($urandom_range(0, 499) != 0);
      s.freq_ce    = ($urandom_range(0, 3) != 0);
      s.len_tick   = ($urandom_range(0, 7) == 0);
      s.env_tick   = ($urandom_range(0, 7) == 0);
      s.sweep_tick = ($urandom_range(0, 7) == 0);
      s.trig       = ($urandom_range(0, 29) == 0);
      s.len_load   = ($urandom_range(0, 59) == 0);
      s.len_data   = 6'($urandom_range(0, 63));
      applyStimulus(s);
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
